// File: rtl/matrix_load_dma.sv
// Bus-master DMA that streams operand matrices A and B from RAM into the matrix
// multiplier's operand FIFO ports, then writes the multiplier's start register.
module matrix_load_dma #(
    parameter int unsigned N       = 2,
    parameter logic [7:0]  A_DST   = 8'h00,
    parameter logic [7:0]  B_DST   = 8'h01,
    parameter logic [7:0]  GO_ADDR = 8'h03,
    parameter logic [31:0] GO_VAL  = 32'h1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  a_base,
    input  logic [7:0]  b_base,
    output logic        busy,
    output logic        done,
    output logic        M1_req,
    input  logic        M1_grant,
    output logic        M1_wr,
    output logic [7:0]  M1_address,
    output logic [31:0] M1_dout,
    input  logic [31:0] M_din
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_J = CW'(N - 1);
    localparam logic [CW-1:0] LAST_K = CW'(N * N - 1);

    typedef enum logic [2:0] {IDLE, REQ, RD, LAT, WR, GO, FIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_base_q, a_base_d, b_base_q, b_base_d;
    logic            phase_q, phase_d;
    logic [CW-1:0]   outer_q, outer_d, rep_q, rep_d, inner_q, inner_d;
    logic            all_done_q, all_done_d;
    logic [AW-1:0]   src;
    logic            busy_d, done_d, req_d, wr_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   dout_d;

    // Next state and loop counters; a transfer only advances on a granted WR,
    // so any grant loss replays the current element from a fresh read.
    always_comb begin
        state_d    = state_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        phase_d    = phase_q;
        outer_d    = outer_q;
        rep_d      = rep_q;
        inner_d    = inner_q;
        all_done_d = all_done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_base_d   = a_base;
                    b_base_d   = b_base;
                    phase_d    = 1'b0;
                    outer_d    = '0;
                    rep_d      = '0;
                    inner_d    = '0;
                    all_done_d = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (M1_grant) state_d = all_done_q ? GO : RD;
            end
            RD:  state_d = M1_grant ? LAT : REQ;
            LAT: state_d = M1_grant ? WR : REQ;
            WR: begin
                if (!M1_grant) begin
                    state_d = REQ;
                end else if (!phase_q) begin
                    state_d = RD;
                    if (inner_q == LAST_J) begin
                        inner_d = '0;
                        if (rep_q == LAST_J) begin
                            rep_d = '0;
                            if (outer_q == LAST_J) begin
                                outer_d = '0;
                                phase_d = 1'b1;
                            end else begin
                                outer_d = outer_q + CW'(1);
                            end
                        end else begin
                            rep_d = rep_q + CW'(1);
                        end
                    end else begin
                        inner_d = inner_q + CW'(1);
                    end
                end else begin
                    state_d = RD;
                    if (inner_q == LAST_K) begin
                        inner_d = '0;
                        if (rep_q == LAST_J) begin
                            all_done_d = 1'b1;
                            state_d    = GO;
                        end else begin
                            rep_d = rep_q + CW'(1);
                        end
                    end else begin
                        inner_d = inner_q + CW'(1);
                    end
                end
            end
            GO:      state_d = M1_grant ? FIN : REQ;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Source address of the element about to be read, modulo 256.
    always_comb begin
        src = '0;
        if (phase_d) src = b_base_d + AW'(inner_d);
        else         src = a_base_d + AW'(outer_d * N) + AW'(inner_d);
    end

    // Output values for the state being entered; registered below.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        req_d  = (state_d inside {REQ, RD, LAT, WR, GO});
        wr_d   = 1'b0;
        addr_d = '0;
        dout_d = '0;
        case (state_d)
            RD, LAT: addr_d = src;
            WR: begin
                wr_d   = 1'b1;
                addr_d = phase_d ? B_DST : A_DST;
                dout_d = M_din;
            end
            GO: begin
                wr_d   = 1'b1;
                addr_d = GO_ADDR;
                dout_d = GO_VAL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_base_q   <= '0;
            b_base_q   <= '0;
            phase_q    <= 1'b0;
            outer_q    <= '0;
            rep_q      <= '0;
            inner_q    <= '0;
            all_done_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            M1_req     <= 1'b0;
            M1_wr      <= 1'b0;
            M1_address <= '0;
            M1_dout    <= '0;
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            phase_q    <= phase_d;
            outer_q    <= outer_d;
            rep_q      <= rep_d;
            inner_q    <= inner_d;
            all_done_q <= all_done_d;
            busy       <= busy_d;
            done       <= done_d;
            M1_req     <= req_d;
            M1_wr      <= wr_d;
            M1_address <= addr_d;
            M1_dout    <= dout_d;
        end
    end

endmodule

// File: doc/matrix_load_dma.md
Name: matrix_load_dma

Overview:
- Bus master (M1 slot) that streams operand matrices A and B from bus RAM into the matrix multiplier's operand FIFO ports, then writes the multiplier's start register.
- Sits directly upstream of the matrix multiplier on the shared bus. Replaces the software read/write loop that M0 otherwise issues.
- One transfer = bus read of a RAM word, then bus write of that word to the A or B FIFO port.

Parameters:
- N, 2, matrix dimension (N x N, N in 1..4)
- A_DST, 8'h00, bus address of multiplier A-FIFO write port
- B_DST, 8'h01, bus address of multiplier B-FIFO write port
- GO_ADDR, 8'h03, bus address of multiplier operation-start register
- GO_VAL, 32'h1, value written to GO_ADDR

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches a load sequence when idle
- a_base  in  8  RAM base address of A, row-major; sampled on accepted start
- b_base  in  8  RAM base address of B, row-major; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after GO write completes
- M1_req  out  1  bus request to arbiter
- M1_grant  in  1  arbiter grant
- M1_wr  out  1  1 = write, 0 = read
- M1_address  out  8  bus address
- M1_dout  out  32  write data
- M_din  in  32  shared bus read data

Behaviour:
- Reset (asynchronous, immediate, any state): state IDLE, counters 0. Outputs reset to busy=0, done=0, M1_req=0, M1_wr=0, M1_address=0, M1_dout=0.
- Bus rules:
  - A read presented in cycle t returns valid M_din in cycle t+1, sampled at the end of t+1.
  - M1_wr, M1_address and M1_dout are meaningful only while M1_grant=1. Otherwise they are driven to 0.
- Transfer order, 2*N^3 transfers total (16 for N=2):
  - Phase A: for i=0..N-1, repeat N times, for j=0..N-1: read a_base+i*N+j, write to A_DST.
  - Phase B: repeat N times, for k=0..N*N-1: read b_base+k, write to B_DST.
  - Address arithmetic is modulo 256 (wraps 8'hFF -> 8'h00).
- States:
  - IDLE: start=1 -> latch bases, clear counters, busy=1, go to REQ. start while busy is ignored.
  - REQ: M1_req=1. Move to RD when M1_grant=1.
  - RD: wr=0, address = source. Next state LAT.
  - LAT: wr=0, address held; capture M_din at the cycle end. Next state WR.
  - WR: wr=1, address = A_DST or B_DST, dout = captured word. Advance the counter. Go to RD, or to GO after the last transfer.
  - GO: wr=1, address=GO_ADDR, dout=GO_VAL. Next state FIN.
  - FIN: M1_req=0, done=1 for one cycle, busy=0. Next state IDLE.
- Each transfer takes 3 granted cycles. Latency from start to done for N=2 with immediate grant is 1 (REQ) + 48 + 1 (GO) + 1 (FIN) = 51 cycles.
- M1_req stays high from REQ through GO, and is released in FIN.
- Grant loss in RD, LAT, WR or GO:
  - Abort the current transfer with no write issued; return to REQ. Completed transfers are kept.
  - Resume at the same element with a fresh read; the element is never written twice.
- Reset mid-sequence: the sequence is abandoned, no done pulse, FIFO contents are the multiplier's concern.

Test Plan:
- RAM[32..35]=10,11,12,13; RAM[64..67]=14,16,15,17; start with a_base=32, b_base=64, grant tied 1:
  - A_DST writes 10,11,10,11,12,13,12,13.
  - B_DST writes 14,16,15,17,14,16,15,17.
  - Then 1 written to addr 3; done at cycle 51, busy low the next cycle.
- Drop M1_grant for 4 cycles during the LAT of the 5th A transfer: exactly one write of 12 to A_DST after regrant, and 16 FIFO writes in total.
- Pulse start again at cycle 10 of a sequence: ignored, so still exactly 16 transfers and one GO.
- a_base=8'hFE with N=2: reads occur at FE, FF, FE, FF, 00, 01, 00, 01 (wrap).
- Assert reset_n=0 in the middle of Phase B: all outputs 0 immediately, no done pulse. A new start after release runs a full 16-transfer sequence.
- N=1, a_base=32, b_base=64: one write of 10 to addr 0, one write of 14 to addr 1, GO write, done after 9 cycles.
